adc_serial_responder: RTL and testbench

Synthesizable responder for the 3-wire serial ADC interface (SCK / CS_N / DIN address in, DOUT data out). It answers the line-sensor ADC master's frames the way the board ADC does. It sits on the FPGA side as a drop-in stand-in for the ADC chip, for hardware-in-the-loop and bench testing of the line-sensor logic. Channel readings come from an 8-entry register bank that host logic writes.

---
 rtl/adc_resp_pkg.sv | 20 ++
 rtl/adc_resp_sync.sv | 32 +++
 rtl/adc_serial_responder.sv | 168 ++++++++++++++++
 tb/tb_adc_serial_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_resp_pkg.sv
// rtl/adc_resp_pkg.sv - shared constants, FSM state type and LFSR step for the serial ADC responder
package adc_resp_pkg;

  localparam int          FRAME_BITS     = 16;
  localparam int          LEAD_ZEROS     = 4;
  localparam int          ADDR_FIRST_BIT = 2;
  localparam int          ADDR_BITS      = 3;
  localparam logic [15:0] LFSR_SEED      = 16'hACE1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Fibonacci LFSR step, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/adc_resp_sync.sv
// rtl/adc_resp_sync.sv - multi-stage input synchronizer with rise/fall edge detect
module adc_resp_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;
  logic                   level;

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

  // shift the pin into the chain; keep the previous synchronized level for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= (chain << 1) | SYNC_STAGES'(din);
      prev  <= level;
    end
  end

endmodule

// File: rtl/adc_serial_responder.sv
// rtl/adc_serial_responder.sv - 3-wire serial ADC stand-in with channel bank; ADC_RESP_NOISE_EN adds LFSR dither
module adc_serial_responder
  import adc_resp_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_50,
  input  logic                    rst_n,
  input  logic                    adc_sck,
  input  logic                    adc_cs_n,
  input  logic                    adc_add,
  output logic                    adc_data,
  input  logic                    ch_wr_en,
  input  logic [$clog2(NCH)-1:0]  ch_wr_addr,
  input  logic [DATA_W-1:0]       ch_wr_data,
  output logic                    frame_done,
  output logic [$clog2(NCH)-1:0]  frame_ch
);

  localparam int AW = $clog2(NCH);
  localparam int CW = $clog2(FRAME_BITS);

  logic                   sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] add_chain;
  logic                   add_bit;

  state_t                 state_q, state_d;
  logic                   load, frame_end;
  logic [AW-1:0]          ld_ch;
  logic [DATA_W-1:0]      bank [NCH];
  logic [DATA_W-1:0]      bank_rd;
  logic [DATA_W-1:0]      load_val;

  logic [FRAME_BITS-1:0]  shift_reg;
  logic [CW-1:0]          bit_cnt;
  logic [ADDR_BITS-1:0]   addr_sr;
  logic [AW-1:0]          cur_ch;
  logic [AW-1:0]          next_ch;

  adc_resp_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk  (clk_50),
    .rst_n(rst_n),
    .din  (adc_sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  adc_resp_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk_50),
    .rst_n(rst_n),
    .din  (adc_cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  assign add_bit = add_chain[SYNC_STAGES-1];

  // address line needs only synchronizing, sampled on detected sck rises
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) add_chain <= '0;
    else        add_chain <= (add_chain << 1) | SYNC_STAGES'(adc_add);
  end

  // frame state register
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state, frame load and frame end decisions
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (sck_rise && bit_cnt == CW'(FRAME_BITS - 1)) begin
          frame_end = 1'b1;
          load      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // at frame end the freshly captured address selects the back-to-back frame
  assign ld_ch   = frame_end ? AW'(addr_sr) : next_ch;
  assign bank_rd = bank[ld_ch];

`ifdef ADC_RESP_NOISE_EN
  logic [15:0]     lfsr_q;
  logic [DATA_W:0] noisy_sum;

  // dither source advances once per frame load
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n)    lfsr_q <= LFSR_SEED;
    else if (load) lfsr_q <= lfsr_next(lfsr_q);
  end

  // add 0..3 of dither and clip at full scale
  always_comb begin
    noisy_sum = {1'b0, bank_rd} + (DATA_W + 1)'(lfsr_q[1:0]);
    load_val  = noisy_sum[DATA_W] ? {DATA_W{1'b1}} : noisy_sum[DATA_W-1:0];
  end
`else
  assign load_val = bank_rd;
`endif

  // host-written channel bank; a read in the same cycle sees the old value
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) bank[i] <= '0;
    end else if (ch_wr_en) begin
      bank[ch_wr_addr] <= ch_wr_data;
    end
  end

  // frame datapath: load, bit count, address capture, data shift, completion pulse
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      addr_sr    <= '0;
      cur_ch     <= '0;
      next_ch    <= '0;
      adc_data   <= 1'b0;
      frame_done <= 1'b0;
      frame_ch   <= '0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        frame_ch <= cur_ch;
        next_ch  <= AW'(addr_sr);
      end
      if (load) begin
        shift_reg <= {{LEAD_ZEROS{1'b0}}, load_val};
        cur_ch    <= ld_ch;
        bit_cnt   <= '0;
        adc_data  <= 1'b0;
      end else if (state_d == IDLE) begin
        bit_cnt  <= '0;
        adc_data <= 1'b0;
      end else begin
        if (sck_rise) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt >= CW'(ADDR_FIRST_BIT) && bit_cnt < CW'(ADDR_FIRST_BIT + ADDR_BITS))
            addr_sr <= {addr_sr[ADDR_BITS-2:0], add_bit};
        end
        // the fall right after a load belongs to the previous frame's last bit
        if (sck_fall && bit_cnt != '0) begin
          shift_reg <= shift_reg << 1;
          adc_data  <= shift_reg[FRAME_BITS-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_serial_responder.sv
// tb/tb_adc_serial_responder.sv - randomized and directed bench against a frame-level reference model
module tb_adc_serial_responder;

  localparam int H = 11;

  logic        clk_50 = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_sck = 1'b0;
  logic        adc_cs_n = 1'b1;
  logic        adc_add = 1'b0;
  logic        ch_wr_en = 1'b0;
  logic [2:0]  ch_wr_addr = '0;
  logic [11:0] ch_wr_data = '0;
  logic        adc_data;
  logic        frame_done;
  logic [2:0]  frame_ch;

  int          total = 0;
  int          bad = 0;
  logic [11:0] m_bank [8];
  logic [2:0]  m_next;
  int          done_cnt = 0;
  logic [2:0]  done_q [$];

  adc_serial_responder #(.DATA_W(12), .NCH(8), .SYNC_STAGES(2)) dut (
    .clk_50    (clk_50),
    .rst_n     (rst_n),
    .adc_sck   (adc_sck),
    .adc_cs_n  (adc_cs_n),
    .adc_add   (adc_add),
    .adc_data  (adc_data),
    .ch_wr_en  (ch_wr_en),
    .ch_wr_addr(ch_wr_addr),
    .ch_wr_data(ch_wr_data),
    .frame_done(frame_done),
    .frame_ch  (frame_ch)
  );

  always #10 clk_50 = ~clk_50;

  always @(negedge clk_50) begin
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_q.push_back(frame_ch);
    end
  end

  initial begin
    #1800000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic write_bank(input logic [2:0] ch, input logic [11:0] val);
    ch_wr_en   = 1'b1;
    ch_wr_addr = ch;
    ch_wr_data = val;
    cyc(1);
    ch_wr_en   = 1'b0;
    m_bank[ch] = val;
  endtask

  task automatic cs_low();
    adc_cs_n = 1'b0;
    cyc(H);
  endtask

  task automatic cs_high();
    adc_cs_n = 1'b1;
    cyc(H);
  endtask

  // master clocks n bits: data sampled just before each rise, address bits on rises 3..5
  task automatic clock_bits(input logic [2:0] addr, input int n, output logic [15:0] word);
    word = '0;
    for (int i = 0; i < n; i++) begin
      if (i >= 2 && i <= 4) adc_add = addr[4-i];
      else                  adc_add = 1'($urandom_range(0, 1));
      cyc(H);
      word    = {word[14:0], adc_data};
      adc_sck = 1'b1;
      cyc(H);
      adc_sck = 1'b0;
    end
  endtask

  task automatic check_word(input string tag, input logic [15:0] w, input logic [2:0] ch);
    logic [11:0] v;
    v = m_bank[ch];
`ifdef ADC_RESP_NOISE_EN
    begin
      logic [11:0] hi;
      logic        ok;
      hi = (v > 12'hFFC) ? 12'hFFF : v + 12'd3;
      ok = (w[15:12] == 4'h0) && (w[11:0] >= v) && (w[11:0] <= hi);
      if (!ok) $display("note %s word=%0h base=%0h", tag, w, v);
      check(tag, {31'd0, ok}, 32'd1);
    end
`else
    check(tag, {16'd0, w}, {20'd0, v});
`endif
  endtask

  task automatic full_frame(input logic [2:0] addr, input string tag);
    logic [15:0] w;
    logic [2:0]  exp_ch;
    exp_ch = m_next;
    clock_bits(addr, 16, w);
    check_word(tag, w, exp_ch);
    if (done_q.size() == 0) check({tag, "_done"}, 32'd0, 32'd1);
    else                    check({tag, "_ch"}, {29'd0, done_q.pop_front()}, {29'd0, exp_ch});
    m_next = addr;
  endtask

  initial begin
    logic [15:0] w;
    logic [2:0]  ch;
    logic [11:0] oldv, newv;
    int          d0;

    for (int i = 0; i < 8; i++) m_bank[i] = '0;
    m_next = '0;

    cyc(3);
    check("rst_data", {31'd0, adc_data}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_ch", {29'd0, frame_ch}, 32'd0);
    rst_n = 1'b1;
    cyc(3);

    // first frame returns channel 0; its address selects channel 5 next
    write_bank(3'd0, 12'hABC);
    write_bank(3'd5, 12'h123);
    cs_low();
    full_frame(3'b101, "first");
    cs_high();
    cs_low();
    full_frame(3'd0, "addr5");
    cs_high();

    // three back-to-back frames under one chip select
    write_bank(3'd1, 12'h0C8);
    write_bank(3'd2, 12'h7FF);
    d0 = done_cnt;
    cs_low();
    full_frame(3'd1, "b2b0");
    full_frame(3'd2, "b2b1");
    full_frame(3'd0, "b2b2");
    cs_high();
    check("b2b_cnt", done_cnt - d0, 32'd3);

    // abort after 8 rises keeps the pending channel
    cs_low();
    full_frame(3'd3, "pre_abort");
    cs_high();
    d0 = done_cnt;
    cs_low();
    clock_bits(3'd6, 8, w);
    adc_cs_n = 1'b1;
    cyc(H);
    check("abort_data", {31'd0, adc_data}, 32'd0);
    check("abort_done", done_cnt - d0, 32'd0);
    cs_low();
    full_frame(3'd4, "post_abort");
    cs_high();

    // bank write lands in the same cycle as the load caused by cs fall
    ch   = m_next;
    oldv = m_bank[ch];
    newv = ~oldv;
    adc_cs_n = 1'b0;
    cyc(2);
    ch_wr_en   = 1'b1;
    ch_wr_addr = ch;
    ch_wr_data = newv;
    cyc(1);
    ch_wr_en   = 1'b0;
    cyc(H - 3);
    full_frame(ch, "same_old");
    m_bank[ch] = newv;
    full_frame(3'd1, "same_new");
    cs_high();

    // reset in the middle of a frame clears bank and channel state
    cs_low();
    clock_bits(3'd7, 5, w);
    rst_n = 1'b0;
    cyc(1);
    check("mrst_data", {31'd0, adc_data}, 32'd0);
    check("mrst_ch", {29'd0, frame_ch}, 32'd0);
    adc_cs_n = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) m_bank[i] = '0;
    m_next = '0;
    done_q.delete();
    cyc(H);
    cs_low();
    full_frame(3'd2, "post_rst");
    cs_high();

    // randomized groups of frames, bank writes and aborts
    for (int it = 0; it < 25; it++) begin
      int nw, mode, nf;
      nw = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++) write_bank(3'($urandom_range(0, 7)), 12'($urandom));
      mode = $urandom_range(0, 3);
      cs_low();
      if (mode == 0) begin
        d0 = done_cnt;
        clock_bits(3'($urandom_range(0, 7)), $urandom_range(1, 15), w);
        adc_cs_n = 1'b1;
        cyc(H);
        check("rnd_abort_done", done_cnt - d0, 32'd0);
        check("rnd_abort_data", {31'd0, adc_data}, 32'd0);
      end else begin
        nf = $urandom_range(1, 3);
        for (int f = 0; f < nf; f++) full_frame(3'($urandom_range(0, 7)), "rnd");
        cs_high();
      end
    end

`ifdef ADC_RESP_NOISE_EN
    // dither must saturate at full scale and stay within +3 otherwise
    write_bank(3'd0, 12'hFFF);
    cs_low();
    full_frame(3'd0, "noise_pre");
    for (int k = 0; k < 20; k++) full_frame(3'd0, "noise_sat");
    cs_high();
    write_bank(3'd0, 12'h100);
    cs_low();
    for (int k = 0; k < 8; k++) full_frame(3'd0, "noise_rng");
    cs_high();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
